// File: rtl/router_dst_port.sv
// Destination-side output channel of the 1x3 router: byte FIFO with per-entry header marker,
// packet-length tracking on the read side, and a timeout-driven self flush.
module router_dst_port #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             write_enb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lfd_state,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             empty,
  output logic             soft_reset
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = WIDTH - 1;

  localparam logic [AW:0]   PtrOne  = 1;
  localparam logic [CW-1:0] CntOne  = 1;
  localparam logic [TW-1:0] TimOne  = 1;
  localparam logic [TW-1:0] TimLast = TW'(TIMEOUT - 1);

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [CW-1:0]   pkt_cnt;
  logic [TW-1:0]   timer;
  logic [WIDTH:0]  rd_entry;
  logic            do_wr;
  logic            do_rd;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid_out = ~empty;
  // Both strobes are dead during the flush cycle.
  assign do_wr     = write_enb & ~full & ~soft_reset;
  assign do_rd     = read_enb & ~empty & ~soft_reset;
  assign rd_entry  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      timer      <= '0;
      data_out   <= '0;
      soft_reset <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      timer      <= '0;
      data_out   <= '0;
      soft_reset <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PtrOne;
      end

      if (do_rd) begin
        rd_ptr   <= rd_ptr + PtrOne;
        data_out <= rd_entry[WIDTH-1:0];
        // Header carries payload length in [7:2]; +1 accounts for the trailing parity byte.
        if (rd_entry[WIDTH]) begin
          pkt_cnt <= {1'b0, rd_entry[WIDTH-1:2]} + CntOne;
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - CntOne;
        end
      end else if (pkt_cnt == '0) begin
        data_out <= '0;
      end

      if (valid_out && !read_enb) begin
        if (timer == TimLast) begin
          timer      <= '0;
          soft_reset <= 1'b1;
        end else begin
          timer <= timer + TimOne;
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_dst_port.sv
// Scoreboard bench for router_dst_port: queue-based reference model updated on each clock,
// monitor compares outputs on the falling edge.
module tb_router_dst_port;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       write_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic       read_enb = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       soft_reset;

  int tests = 0;
  int fails = 0;
  int soft_seen = 0;
  int snap;

  // Reference model state
  logic [8:0] mq[$];
  logic [7:0] exp_q[$];
  int         m_cnt = 0;
  int         m_timer = 0;
  logic [7:0] m_dout = 8'h00;
  bit         m_soft = 1'b0;

  router_dst_port #(.DEPTH(DEPTH), .WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .write_enb  (write_enb),
    .data_in    (data_in),
    .lfd_state  (lfd_state),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .full       (full),
    .empty      (empty),
    .soft_reset (soft_reset)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_cnt = 0;
    m_timer = 0;
    m_dout = 8'h00;
    m_soft = 1'b0;
  endtask

  task automatic model_step();
    logic [8:0] e;
    int occ;
    bit rd;
    bit wr;
    occ = mq.size();
    if (m_soft) begin
      model_reset();
      return;
    end
    rd = read_enb && occ > 0;
    wr = write_enb && occ < DEPTH;
    if (occ > 0 && !read_enb) begin
      m_timer++;
      if (m_timer == TIMEOUT) begin
        m_soft = 1'b1;
        m_timer = 0;
      end
    end else begin
      m_timer = 0;
    end
    if (rd) begin
      e = mq.pop_front();
      m_dout = e[7:0];
      if (e[8]) m_cnt = int'(e[7:2]) + 1;
      else if (m_cnt > 0) m_cnt--;
      exp_q.push_back(e[7:0]);
    end else if (m_cnt == 0) begin
      m_dout = 8'h00;
    end
    if (wr) mq.push_back({lfd_state, data_in});
  endtask

  initial forever begin
    @(posedge clock);
    if (resetn) model_step();
  end

  // Monitor: pops the scoreboard whenever read data is due and checks flags every cycle.
  initial forever begin
    logic [7:0] e;
    @(negedge clock);
    if (resetn) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("read_data", data_out, e);
      end
      chk("data_out_hold", data_out, m_dout);
      chk("valid_out", valid_out, mq.size() != 0);
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("soft_reset", soft_reset, m_soft);
      if (soft_reset) soft_seen++;
    end
  end

  task automatic drive(input bit we, input logic [7:0] d, input bit lfd, input bit re);
    @(negedge clock);
    write_enb = we;
    data_in   = d;
    lfd_state = lfd;
    read_enb  = re;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"}, data_out, 8'h00);
    chk({tag, "_valid_out"}, valid_out, 1'b0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_soft_reset"}, soft_reset, 1'b0);
  endtask

  initial begin
    logic [7:0] pkt [5];
    pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5E;

    repeat (2) @(negedge clock);
    check_reset_outputs("por");
    resetn = 1'b1;

    // Packet delivery; data_out returns to zero once the parity byte is out.
    for (int i = 0; i < 5; i++) drive(1'b1, pkt[i], i == 0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(3);
    chk("pkt_data_zero", data_out, 8'h00);
    chk("pkt_empty", empty, 1'b1);

    // Fill past capacity, then read+write while full, then drain.
    for (int i = 0; i <= 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fill_full", full, 1'b1);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    chk("drain_empty", empty, 1'b1);

    // Read+write while empty: write lands, read ignored.
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    idle(1);
    chk("conc_empty_valid", valid_out, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Async reset in the middle of a long packet and a write stream.
    drive(1'b1, 8'hFC, 1'b1, 1'b0);
    drive(1'b1, 8'h11, 1'b0, 1'b1);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async");
    @(negedge clock);
    write_enb = 1'b0;
    resetn = 1'b1;
    idle(2);

    // Timeout flush with unserviced data.
    snap = soft_seen;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    idle(35);
    chk("timeout_pulses", soft_seen - snap, 1);
    chk("timeout_empty", empty, 1'b1);

    // Servicing just before the limit keeps the data.
    snap = soft_seen;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    idle(26);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(35);
    chk("no_timeout_pulses", soft_seen - snap, 0);

    // Pointer wrap at low occupancy.
    for (int i = 0; i < 40; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0, i >= 2);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);
    chk("wrap_empty", empty, 1'b1);

    // Randomized traffic, alternating read-heavy and read-starved phases.
    for (int i = 0; i < 600; i++) begin
      if ((i / 150) % 2 == 0)
        drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0);
      else
        drive($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 15) == 0);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
